axis_burst_arbiter: RTL and testbench

Packet-level round-robin arbiter that lets several AXI-stream burst sources share one downstream AXI-stream link. The sources are the per-receiver peak-detector outputs, each emitting fixed-length, tlast-terminated capture bursts. A grant is held from the first beat until the tlast handshake, so bursts are never interleaved. Every output beat is tagged with its source index, and a per-burst stall watchdog releases a grant whose source has hung.

---
 rtl/axis_burst_arbiter.sv | 148 ++++++++++++++
 tb/tb_axis_burst_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_burst_arbiter.sv
// Packet-level round-robin arbiter merging NUM_PORTS tlast-terminated AXI-stream bursts
// onto one registered output, tagging each beat with its source and abandoning hung bursts.
module axis_burst_arbiter #(
   parameter int NUM_PORTS    = 4,
   parameter int DATA_WIDTH   = 256,
   parameter int IDLE_TIMEOUT = 64
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [NUM_PORTS-1:0]              s_axis_tvalid,
   output logic [NUM_PORTS-1:0]              s_axis_tready,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0]   s_axis_tdata,
   input  logic [NUM_PORTS-1:0]              s_axis_tlast,
   output logic                              m_axis_tvalid,
   input  logic                              m_axis_tready,
   output logic [DATA_WIDTH-1:0]             m_axis_tdata,
   output logic                              m_axis_tlast,
   output logic [$clog2(NUM_PORTS)-1:0]      m_axis_tuser,
   output logic                              timeout_pulse
);

   localparam int SEL_WIDTH = $clog2(NUM_PORTS);
   localparam int CNT_WIDTH = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'((IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT : 0);
   localparam logic [CNT_WIDTH-1:0] CNT_LAST =
      CNT_WIDTH'((IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT - 1 : 0);
   localparam logic [SEL_WIDTH-1:0] PTR_RESET = SEL_WIDTH'(NUM_PORTS - 1);

   typedef enum logic {StIdle, StPass} state_e;

   state_e                 state_q, state_d;
   logic [SEL_WIDTH-1:0]   grant_q, grant_d;
   logic [SEL_WIDTH-1:0]   ptr_q, ptr_d;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
   logic                   m_valid_q, m_valid_d;
   logic [DATA_WIDTH-1:0]  m_data_q, m_data_d;
   logic                   m_last_q, m_last_d;
   logic [SEL_WIDTH-1:0]   m_user_q, m_user_d;

   logic                   arb_found;
   logic [SEL_WIDTH-1:0]   arb_sel;
   logic [SEL_WIDTH-1:0]   cand;
   logic                   out_free;
   logic                   src_hs;

   // Round-robin search starting just after the last served port.
   always_comb begin
      arb_found = 1'b0;
      arb_sel   = '0;
      cand      = '0;
      for (int i = 1; i <= NUM_PORTS; i++) begin
         cand = SEL_WIDTH'((int'(ptr_q) + i) % NUM_PORTS);
         if (!arb_found && s_axis_tvalid[cand]) begin
            arb_found = 1'b1;
            arb_sel   = cand;
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      ptr_d         = ptr_q;
      cnt_d         = cnt_q;
      m_valid_d     = m_valid_q;
      m_data_d      = m_data_q;
      m_last_d      = m_last_q;
      m_user_d      = m_user_q;
      s_axis_tready = '0;
      timeout_pulse = 1'b0;
      out_free      = ~m_valid_q | m_axis_tready;
      src_hs        = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (arb_found) begin
               grant_d = arb_sel;
               cnt_d   = '0;
               state_d = StPass;
            end
         end
         StPass: begin
            s_axis_tready[grant_q] = out_free;
            src_hs = s_axis_tvalid[grant_q] & out_free;
            if (src_hs) begin
               cnt_d = '0;
               if (s_axis_tlast[grant_q]) begin
                  ptr_d   = grant_q;
                  state_d = StIdle;
               end
            end else if (!s_axis_tvalid[grant_q] && (IDLE_TIMEOUT > 0)) begin
               // Only source-side silence counts; output backpressure keeps valid high.
               if (cnt_q == CNT_LAST) begin
                  timeout_pulse = 1'b1;
                  ptr_d         = grant_q;
                  cnt_d         = '0;
                  state_d       = StIdle;
               end else if (cnt_q != CNT_MAX) begin
                  cnt_d = cnt_q + CNT_WIDTH'(1);
               end
            end
         end
         default: state_d = StIdle;
      endcase

      if (src_hs) begin
         m_valid_d = 1'b1;
         m_data_d  = s_axis_tdata[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
         m_last_d  = s_axis_tlast[grant_q];
         m_user_d  = grant_q;
      end else if (m_valid_q && m_axis_tready) begin
         m_valid_d = 1'b0;
      end

      if (rst) begin
         s_axis_tready = '0;
         timeout_pulse = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         grant_q   <= '0;
         ptr_q     <= PTR_RESET;
         cnt_q     <= '0;
         m_valid_q <= 1'b0;
         m_data_q  <= '0;
         m_last_q  <= 1'b0;
         m_user_q  <= '0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
         m_valid_q <= m_valid_d;
         m_data_q  <= m_data_d;
         m_last_q  <= m_last_d;
         m_user_q  <= m_user_d;
      end
   end

   assign m_axis_tvalid = m_valid_q;
   assign m_axis_tdata  = m_data_q;
   assign m_axis_tlast  = m_last_q;
   assign m_axis_tuser  = m_user_q;

endmodule

// File: tb/tb_axis_burst_arbiter.sv
// Scoreboard bench for axis_burst_arbiter: directed bursts feed an expected-beat queue
// that a negedge monitor drains against the output stream.
module tb_axis_burst_arbiter;

   localparam int NP = 4;
   localparam int DW = 32;
   localparam int TO = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [NP-1:0]    s_tvalid = '0;
   logic [NP-1:0]    s_tready;
   logic [NP*DW-1:0] s_tdata = '0;
   logic [NP-1:0]    s_tlast = '0;
   logic             m_tvalid;
   logic             m_tready = 1'b1;
   logic [DW-1:0]    m_tdata;
   logic             m_tlast;
   logic [1:0]       m_tuser;
   logic             tpulse;

   always #5 clk = ~clk;

   axis_burst_arbiter #(
      .NUM_PORTS    (NP),
      .DATA_WIDTH   (DW),
      .IDLE_TIMEOUT (TO)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tready (s_tready),
      .s_axis_tdata  (s_tdata),
      .s_axis_tlast  (s_tlast),
      .m_axis_tvalid (m_tvalid),
      .m_axis_tready (m_tready),
      .m_axis_tdata  (m_tdata),
      .m_axis_tlast  (m_tlast),
      .m_axis_tuser  (m_tuser),
      .timeout_pulse (tpulse)
   );

   typedef struct packed {logic [DW-1:0] data; logic last; logic [1:0] user;} beat_t;
   typedef struct packed {logic [DW-1:0] data; logic last; logic [7:0] gap;} src_t;

   beat_t exp_q[$];
   src_t  srcq[NP][$];

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   logic rst_at_edge = 1'b1;
   logic [NP-1:0] hs_flag = '0;
   int hs_cnt[NP];
   int last_hs_cyc[NP];
   int rise_cyc = 0;
   int mv_first_cyc = 0;
   logic mv_armed = 1'b0;
   logic prev_mv = 1'b0;
   logic [NP-1:0] prev_sv = '0;
   int pulse_cnt = 0;
   int pulse_cyc = 0;
   logic gap_chk_en = 1'b0;
   logic have_tlast = 1'b0;
   int tlast_cyc = 0;
   int gaps_seen = 0;
   logic prev_stall = 1'b0;
   beat_t saved;
   logic ready_toggle = 1'b0;
   int rdy_cnt = 0;

   task automatic check(input string name, input longint act, input longint req);
      n_chk++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   always @(posedge clk) begin
      cyc         <= cyc + 1;
      rst_at_edge <= rst;
   end

   // Monitor: scoreboard pop, hold-stability, source handshakes, pulses.
   always @(negedge clk) begin
      beat_t got;
      got = {m_tdata, m_tlast, m_tuser};
      if (!rst_at_edge) begin
         if (prev_stall) begin
            check("hold_valid", longint'(m_tvalid), 1);
            check("hold_beat", longint'(got), longint'(saved));
         end
         if (m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_beat: got %0h expected none", got);
            end else begin
               check("beat", longint'(got), longint'(exp_q.pop_front()));
            end
         end
         if (tpulse) begin
            pulse_cnt++;
            pulse_cyc = cyc;
         end
      end
      prev_stall = m_tvalid & ~m_tready & ~rst_at_edge;
      saved = got;
      if (!gap_chk_en) have_tlast = 1'b0;
      for (int p = 0; p < NP; p++) begin
         hs_flag[p] = s_tvalid[p] & s_tready[p];
         if (hs_flag[p]) begin
            hs_cnt[p]++;
            last_hs_cyc[p] = cyc;
            if (gap_chk_en && have_tlast) begin
               check("burst_gap", cyc - tlast_cyc, 2);
               gaps_seen++;
            end
            have_tlast = s_tlast[p];
            tlast_cyc = cyc;
         end
      end
      if (|(s_tvalid & ~prev_sv)) begin
         rise_cyc = cyc;
         mv_armed = 1'b1;
      end else if (m_tvalid && !prev_mv && mv_armed) begin
         mv_first_cyc = cyc;
         mv_armed = 1'b0;
      end
      prev_sv = s_tvalid;
      prev_mv = m_tvalid;
   end

   // Source and sink drivers.
   always @(posedge clk) begin
      src_t it;
      #1;
      for (int p = 0; p < NP; p++) begin
         if (hs_flag[p] && srcq[p].size() > 0) void'(srcq[p].pop_front());
         s_tvalid[p] = 1'b0;
         if (srcq[p].size() > 0) begin
            it = srcq[p][0];
            if (it.gap != 0) begin
               it.gap = it.gap - 8'd1;
               srcq[p][0] = it;
            end else begin
               s_tvalid[p] = 1'b1;
               s_tdata[p*DW +: DW] = it.data;
               s_tlast[p] = it.last;
            end
         end
      end
      rdy_cnt++;
      m_tready = ready_toggle ? ((rdy_cnt % 4 == 0) || (rdy_cnt % 4 == 3)) : 1'b1;
   end

   task automatic tick();
      @(negedge clk);
      #2;
   endtask

   task automatic add_src(input int p, input logic [DW-1:0] d, input logic l, input int gap);
      src_t it;
      it.data = d;
      it.last = l;
      it.gap  = 8'(gap);
      srcq[p].push_back(it);
   endtask

   task automatic add_exp(input logic [DW-1:0] d, input logic l, input int u);
      beat_t b;
      b.data = d;
      b.last = l;
      b.user = 2'(u);
      exp_q.push_back(b);
   endtask

   task automatic burst(input int p, input int n, input logic [DW-1:0] base, input logic term,
                        input logic expect_it);
      for (int i = 0; i < n; i++) begin
         add_src(p, base + DW'(i), term && (i == n - 1), 0);
         if (expect_it) add_exp(base + DW'(i), term && (i == n - 1), p);
      end
   endtask

   task automatic flush_src();
      for (int p = 0; p < NP; p++) srcq[p].delete();
   endtask

   task automatic reset_dut();
      tick();
      rst = 1'b1;
      flush_src();
      exp_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget);
      int i;
      i = 0;
      while (exp_q.size() != 0 && i < budget) begin
         tick();
         i++;
      end
      if (i >= budget) begin
         n_chk++;
         n_fail++;
         $display("FAIL %s_timeout: got %0d beats pending expected 0", name, exp_q.size());
      end
      repeat (4) tick();
   endtask

   initial begin
      int pbase;
      int gbase;
      int hbase;
      int k;
      for (int p = 0; p < NP; p++) begin
         hs_cnt[p] = 0;
         last_hs_cyc[p] = 0;
      end
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_m_tvalid", longint'(m_tvalid), 0);
      check("rst_s_tready", longint'(s_tready), 0);
      check("rst_m_tdata", longint'(m_tdata), 0);
      check("rst_m_tlast", longint'(m_tlast), 0);
      check("rst_m_tuser", longint'(m_tuser), 0);
      check("rst_pulse", longint'(tpulse), 0);

      // 1: single source, 32 beats on port 2.
      tick();
      pbase = pulse_cnt;
      burst(2, 32, 32'd0, 1'b1, 1'b1);
      wait_done("single", 200);
      check("first_beat_latency", mv_first_cyc - rise_cyc, 2);
      check("single_no_pulse", pulse_cnt - pbase, 0);

      // 2: contention, order 0,1,3,0.
      reset_dut();
      gap_chk_en = 1'b1;
      gbase = gaps_seen;
      burst(0, 4, 32'h0A00, 1'b1, 1'b1);
      burst(1, 4, 32'h1100, 1'b1, 1'b1);
      burst(3, 4, 32'h3300, 1'b1, 1'b1);
      burst(0, 4, 32'h0B00, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) add_exp(32'h0B00 + DW'(i), i == 3, 0);
      wait_done("contention", 200);
      gap_chk_en = 1'b0;
      check("gaps_checked", gaps_seen - gbase, 3);

      // 3: backpressure 1,0,0,1 during a 16-beat burst.
      reset_dut();
      pbase = pulse_cnt;
      ready_toggle = 1'b1;
      burst(3, 16, 32'h7700, 1'b1, 1'b1);
      wait_done("backpressure", 300);
      ready_toggle = 1'b0;
      check("bp_no_pulse", pulse_cnt - pbase, 0);

      // 4: watchdog abandons port 1 after 3 beats, port 2 follows.
      reset_dut();
      pbase = pulse_cnt;
      burst(1, 3, 32'h4100, 1'b0, 1'b1);
      burst(2, 4, 32'h4200, 1'b1, 1'b1);
      wait_done("watchdog", 200);
      check("wd_pulse_count", pulse_cnt - pbase, 1);
      check("wd_pulse_delay", pulse_cyc - last_hs_cyc[1], 8);

      // 5: reset in the middle of a 32-beat burst.
      reset_dut();
      burst(2, 2, 32'h5200, 1'b1, 1'b1);
      burst(2, 32, 32'h5300, 1'b1, 1'b1);
      hbase = hs_cnt[2];
      k = 0;
      while (hs_cnt[2] < hbase + 7 && k < 200) begin
         tick();
         k++;
      end
      check("mid_burst_reached", longint'(hs_cnt[2] >= hbase + 7), 1);
      rst = 1'b1;
      flush_src();
      exp_q.delete();
      burst(3, 4, 32'h5400, 1'b1, 1'b0);
      burst(1, 4, 32'h5100, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("mid_rst_m_tvalid", longint'(m_tvalid), 0);
      check("mid_rst_s_tready", longint'(s_tready), 0);
      for (int i = 0; i < 4; i++) add_exp(32'h5100 + DW'(i), i == 3, 1);
      for (int i = 0; i < 4; i++) add_exp(32'h5400 + DW'(i), i == 3, 3);
      wait_done("after_reset", 200);

      // 6: tlast arrives on the cycle the stall count would expire.
      reset_dut();
      pbase = pulse_cnt;
      add_src(0, 32'h6000, 1'b0, 0);
      add_src(0, 32'h6001, 1'b1, 7);
      add_exp(32'h6000, 1'b0, 0);
      add_exp(32'h6001, 1'b1, 0);
      wait_done("coincide", 100);
      check("coincide_no_pulse", pulse_cnt - pbase, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
